// File: rtl/reset_sequencer_pkg.sv
// Shared types and sizing helpers for the reset sequencer.
//   rs_state_e    : sequencer FSM states
//   cnt_width()   : width of a counter that must hold max(a, b)
//   SOFT_CNT_W/MAX: soft-request counter width and saturation value
package reset_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_ASSERT  = 2'd0,
      ST_HOLD    = 2'd1,
      ST_RELEASE = 2'd2,
      ST_DONE    = 2'd3
   } rs_state_e;

   localparam int unsigned SOFT_CNT_W = 8;
   localparam logic [SOFT_CNT_W-1:0] SOFT_CNT_MAX = 8'd255;

   // Bits needed to represent values 0..max(a, b).
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset release synchronizer: asserts asynchronously, releases on the
// SYNC_STAGES-th rising clk edge after async_reset_n goes high.
//   clk           : sequencer clock
//   async_reset_n : board reset, active low
//   sync_release  : high once the release has crossed into the clk domain
module reset_sync_chain #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic async_reset_n,
   output logic sync_release
);

   logic [SYNC_STAGES-1:0] sync_q;

   // Shift a constant 1 through the chain; clear on async assertion.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
      end
   end

   assign sync_release = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Ordered per-domain reset bring-up with software re-sequence.
//   clk              : clock from the clock generator
//   async_reset_n    : board reset, active low, asynchronous
//   soft_reset_req   : synchronous request to restart the sequence
//   rst_n_out        : per-domain active-low resets, bit 0 released first
//   reset_done       : high once every domain is released
//   soft_reset_count : accepted soft requests, saturating at 255
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned HOLD_CYCLES = 16,
   parameter int unsigned STAGE_DELAY = 4,
   parameter int unsigned NUM_DOMAINS = 3
) (
   input  logic                   clk,
   input  logic                   async_reset_n,
   input  logic                   soft_reset_req,
   output logic [NUM_DOMAINS-1:0] rst_n_out,
   output logic                   reset_done,
   output logic [SOFT_CNT_W-1:0]  soft_reset_count
);

   localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, STAGE_DELAY);
   localparam int unsigned IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
   localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'((NUM_DOMAINS > 1) ? 1 : 0);

   rs_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [NUM_DOMAINS-1:0]  rst_d;
   logic                    done_d;
   logic [SOFT_CNT_W-1:0]   soft_cnt_d;

   logic                    sync_release;
   logic                    soft_accept;
   logic                    hold_tick;
   logic [CNT_W-1:0]        hold_cnt;
   logic                    hold_end;
   logic                    stage_end;
   logic                    last_stage;

   reset_sync_chain #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk           (clk),
      .async_reset_n (async_reset_n),
      .sync_release  (sync_release)
   );

   // The edge on which ASSERT sees sync_release already counts as the
   // first HOLD cycle, so the hold window starts on edge SYNC_STAGES.
   always_comb begin
      soft_accept = soft_reset_req && (state_q != ST_ASSERT);
      hold_tick   = (state_q == ST_HOLD) || ((state_q == ST_ASSERT) && sync_release);
      hold_cnt    = (state_q == ST_ASSERT) ? '0 : cnt_q;
      hold_end    = hold_tick && (hold_cnt == CNT_W'(HOLD_CYCLES - 1));
      stage_end   = (state_q == ST_RELEASE) && (cnt_q == CNT_W'(STAGE_DELAY - 1));
      last_stage  = (idx_q == IDX_W'(NUM_DOMAINS - 1));
   end

   // State register plus registered outputs and counters.
   always_ff @(posedge clk or negedge async_reset_n) begin
      if (!async_reset_n) begin
         state_q          <= ST_ASSERT;
         cnt_q            <= '0;
         idx_q            <= '0;
         rst_n_out        <= '0;
         reset_done       <= 1'b0;
         soft_reset_count <= '0;
      end else begin
         state_q          <= state_d;
         cnt_q            <= cnt_d;
         idx_q            <= idx_d;
         rst_n_out        <= rst_d;
         reset_done       <= done_d;
         soft_reset_count <= soft_cnt_d;
      end
   end

   // Next-state logic; an accepted soft request overrides any release.
   always_comb begin
      state_d = state_q;
      if (soft_accept) begin
         state_d = ST_HOLD;
      end else begin
         case (state_q)
            ST_ASSERT, ST_HOLD: begin
               if (hold_end) begin
                  state_d = (NUM_DOMAINS == 1) ? ST_DONE : ST_RELEASE;
               end else if (hold_tick) begin
                  state_d = ST_HOLD;
               end
            end
            ST_RELEASE: begin
               if (stage_end && last_stage) begin
                  state_d = ST_DONE;
               end
            end
            ST_DONE: state_d = ST_DONE;
            default: state_d = ST_ASSERT;
         endcase
      end
   end

   // Next values of counters and registered outputs.
   always_comb begin
      cnt_d      = cnt_q;
      idx_d      = idx_q;
      rst_d      = rst_n_out;
      done_d     = reset_done;
      soft_cnt_d = soft_reset_count;
      if (soft_accept) begin
         cnt_d  = '0;
         rst_d  = '0;
         done_d = 1'b0;
         if (soft_reset_count != SOFT_CNT_MAX) begin
            soft_cnt_d = soft_reset_count + SOFT_CNT_W'(1);
         end
      end else if (hold_end) begin
         cnt_d    = '0;
         idx_d    = IDX_FIRST;
         rst_d[0] = 1'b1;
         if (NUM_DOMAINS == 1) begin
            done_d = 1'b1;
         end
      end else if (hold_tick) begin
         cnt_d = hold_cnt + CNT_W'(1);
      end else if (state_q == ST_RELEASE) begin
         if (stage_end) begin
            cnt_d = '0;
            for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
               if (idx_q == IDX_W'(i)) begin
                  rst_d[i] = 1'b1;
               end
            end
            if (last_stage) begin
               done_d = 1'b1;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build plus a minimal build
// (NUM_DOMAINS=1, SYNC_STAGES=3, HOLD_CYCLES=1, STAGE_DELAY=1).
module tb_reset_sequencer;

   logic       clk;
   logic       arst_n;
   logic       soft_req;
   logic [2:0] rst_n_out;
   logic       reset_done;
   logic [7:0] soft_count;

   logic       arst2_n;
   logic       soft2;
   logic [0:0] rst2;
   logic       done2;
   logic [7:0] count2;

   int checks;
   int errors;

   reset_sequencer u_dut (
      .clk              (clk),
      .async_reset_n    (arst_n),
      .soft_reset_req   (soft_req),
      .rst_n_out        (rst_n_out),
      .reset_done       (reset_done),
      .soft_reset_count (soft_count)
   );

   reset_sequencer #(
      .SYNC_STAGES (3),
      .HOLD_CYCLES (1),
      .STAGE_DELAY (1),
      .NUM_DOMAINS (1)
   ) u_dut2 (
      .clk              (clk),
      .async_reset_n    (arst2_n),
      .soft_reset_req   (soft2),
      .rst_n_out        (rst2),
      .reset_done       (done2),
      .soft_reset_count (count2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected {reset_done, rst_n_out} at edge e when bit 0 releases at base.
   function automatic logic [3:0] exp_vec(input int e, input int base);
      logic [3:0] v;
      for (int i = 0; i < 3; i++) v[i] = (e >= base + i * 4);
      v[3] = (e >= base + 8);
      return v;
   endfunction

   task automatic test_reset();
      arst_n = 1'b1; soft_req = 1'b0; arst2_n = 1'b1; soft2 = 1'b0;
      #1;
      arst_n = 1'b0; arst2_n = 1'b0;
      #1;
      checks++;
      if ({reset_done, rst_n_out, soft_count} !== 12'h000) begin
         errors++;
         $display("FAIL reset_state got=%h want=000", {reset_done, rst_n_out, soft_count});
      end
      checks++;
      if ({done2, rst2, count2} !== 10'h000) begin
         errors++;
         $display("FAIL reset_state_min got=%h want=000", {done2, rst2, count2});
      end
   endtask

   task automatic test_powerup();
      @(negedge clk);
      arst_n = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== exp_vec(e, 18)) begin
            errors++;
            $display("FAIL powerup edge=%0d got=%b want=%b", e, {reset_done, rst_n_out}, exp_vec(e, 18));
         end
      end
      checks++;
      if (soft_count !== 8'd0) begin
         errors++;
         $display("FAIL powerup_count got=%0d want=0", soft_count);
      end
   endtask

   // Continues from power-up edge 30; request sampled on edge 40.
   task automatic test_soft_done();
      for (int e = 31; e <= 39; e++) tick();
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      checks++;
      if ({reset_done, rst_n_out, soft_count} !== {4'b0000, 8'd1}) begin
         errors++;
         $display("FAIL soft_done_accept got=%b/%0d want=0000/1", {reset_done, rst_n_out}, soft_count);
      end
      for (int e = 41; e <= 66; e++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== exp_vec(e, 56)) begin
            errors++;
            $display("FAIL soft_done edge=%0d got=%b want=%b", e, {reset_done, rst_n_out}, exp_vec(e, 56));
         end
      end
   endtask

   task automatic test_soft_held();
      soft_req = 1'b1;
      for (int j = 1; j <= 300; j++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== 4'b0000) begin
            errors++;
            $display("FAIL soft_held_low j=%0d got=%b want=0000", j, {reset_done, rst_n_out});
         end
         if (j == 10) begin
            checks++;
            if (soft_count !== 8'd11) begin
               errors++;
               $display("FAIL soft_held_count10 got=%0d want=11", soft_count);
            end
         end
      end
      soft_req = 1'b0;
      checks++;
      if (soft_count !== 8'd255) begin
         errors++;
         $display("FAIL soft_held_sat got=%0d want=255", soft_count);
      end
      for (int j = 301; j <= 326; j++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== exp_vec(j, 316)) begin
            errors++;
            $display("FAIL soft_held_release j=%0d got=%b want=%b", j, {reset_done, rst_n_out}, exp_vec(j, 316));
         end
      end
   endtask

   task automatic test_async_mid();
      arst_n = 1'b0;
      #2;
      @(negedge clk);
      arst_n = 1'b1;
      for (int e = 1; e <= 20; e++) tick();
      checks++;
      if ({reset_done, rst_n_out} !== 4'b0001) begin
         errors++;
         $display("FAIL async_mid_pre got=%b want=0001", {reset_done, rst_n_out});
      end
      arst_n = 1'b0;
      #1;
      checks++;
      if ({reset_done, rst_n_out, soft_count} !== 12'h000) begin
         errors++;
         $display("FAIL async_mid_drop got=%h want=000", {reset_done, rst_n_out, soft_count});
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      for (int e = 1; e <= 30; e++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== exp_vec(e, 18)) begin
            errors++;
            $display("FAIL async_mid_repeat edge=%0d got=%b want=%b", e, {reset_done, rst_n_out}, exp_vec(e, 18));
         end
      end
   endtask

   task automatic test_soft_assert_and_coincident();
      arst_n   = 1'b0;
      soft_req = 1'b1;
      #2;
      @(negedge clk);
      arst_n = 1'b1;
      tick();
      tick();
      soft_req = 1'b0;
      checks++;
      if ({reset_done, rst_n_out, soft_count} !== 12'h000) begin
         errors++;
         $display("FAIL soft_in_assert got=%h want=000", {reset_done, rst_n_out, soft_count});
      end
      for (int e = 3; e <= 21; e++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== exp_vec(e, 18)) begin
            errors++;
            $display("FAIL coincident_pre edge=%0d got=%b want=%b", e, {reset_done, rst_n_out}, exp_vec(e, 18));
         end
      end
      soft_req = 1'b1;
      tick();
      soft_req = 1'b0;
      checks++;
      if ({reset_done, rst_n_out, soft_count} !== {4'b0000, 8'd1}) begin
         errors++;
         $display("FAIL coincident_wins got=%b/%0d want=0000/1", {reset_done, rst_n_out}, soft_count);
      end
      for (int e = 23; e <= 48; e++) begin
         tick();
         checks++;
         if ({reset_done, rst_n_out} !== exp_vec(e, 38)) begin
            errors++;
            $display("FAIL coincident_restart edge=%0d got=%b want=%b", e, {reset_done, rst_n_out}, exp_vec(e, 38));
         end
      end
   endtask

   task automatic test_min_params();
      @(negedge clk);
      arst2_n = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         logic [1:0] want;
         tick();
         want = (e >= 4) ? 2'b11 : 2'b00;
         checks++;
         if ({done2, rst2} !== want || $isunknown(u_dut2.idx_q)) begin
            errors++;
            $display("FAIL min_powerup edge=%0d got=%b want=%b", e, {done2, rst2}, want);
         end
      end
      tick();
      soft2 = 1'b1;
      tick();
      soft2 = 1'b0;
      checks++;
      if ({done2, rst2, count2} !== {2'b00, 8'd1}) begin
         errors++;
         $display("FAIL min_soft_accept got=%b/%0d want=00/1", {done2, rst2}, count2);
      end
      tick();
      checks++;
      if ({done2, rst2} !== 2'b11) begin
         errors++;
         $display("FAIL min_soft_release got=%b want=11", {done2, rst2});
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_powerup();
      test_soft_done();
      test_soft_held();
      test_async_mid();
      test_soft_assert_and_coincident();
      test_min_params();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
